fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the pipelined LC-3b core; the direct upstream feeder of the decode-stage control ROM.
- Owns the PC and the instruction-memory read handshake.
- Registers the fetched IR and PC+2 into the IF/ID latch, and pre-extracts the decode fields the control ROM consumes (opcode, imm bit, JSR-mode bit, shift-direction bit).
- Handles decode-stage stalls and branch/jump redirects, including a redirect that arrives while a fetch is outstanding.

Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- imem_read  out  1  instruction read request
- imem_address  out  16  byte address of fetch (= pc)
- imem_resp  in  1  one-cycle pulse: imem_rdata valid
- imem_rdata  in  16  fetched instruction
- stall  in  1  IF/ID must hold (load-use/mem hazard downstream)
- redirect  in  1  one-cycle pulse: taken branch/JMP/JSR/TRAP, flush
- redirect_pc  in  16  target PC, valid with redirect
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_pc  out  16  PC+2 of instruction in IF/ID
- ifid_ir  out  16  instruction in IF/ID
- ifid_opcode  out  4  ifid_ir[15:12]
- ifid_imm_check  out  1  ifid_ir[5]
- ifid_jsr_check  out  1  ifid_ir[11]
- ifid_rshf_check  out  1  ifid_ir[4]

Behaviour:
- Reset (async, reset_n=0):
  - pc=PC_RESET, state=REQ, hold register cleared.
  - All ifid_* outputs are 0 (ifid_valid=0).
  - imem_read is forced 0 while reset_n=0.
- PC arithmetic: 16-bit, pc+2 wraps 16'hFFFE -> 16'h0000 with no flag.
- Decode fields are pure slices of the registered ifid_ir; no added latency.
- Memory rule: once imem_read=1, imem_address and imem_read stay stable until the cycle imem_resp=1. There is never more than one request outstanding.
- States:
  - REQ: imem_read=1, imem_address=pc.
    - resp & !redirect & !stall: IF/ID <= {1, pc+2, rdata}; pc<=pc+2; stay REQ. Back-to-back fetch; 1 instr per resp.
    - resp & !redirect & stall: rdata and pc+2 go into the hold register; IF/ID is unchanged; go HOLD.
    - resp & redirect: discard rdata; pc<=redirect_pc; stay REQ (new address next cycle).
    - !resp & redirect: pc<=redirect_pc; go DRAIN.
    - !resp & !redirect: wait.
  - HOLD: imem_read=0.
    - redirect: drop hold; pc<=redirect_pc; go REQ.
    - !stall: IF/ID <= hold contents (valid=1); pc<=pc+2; go REQ.
    - stall: remain.
  - DRAIN: imem_read=1, imem_address = the old (pre-redirect) address, kept in a latched register.
    - resp: discard rdata; go REQ, using the already-updated pc.
    - A further redirect in DRAIN overwrites pc; it does not go through an extra DRAIN.
- IF/ID update priority, highest first:
  1. redirect -> ifid_valid<=0 (flush wins over stall).
  2. stall -> hold all ifid_*.
  3. new instruction -> load it.
  4. otherwise -> ifid_valid<=0 (bubble); ifid_pc and ifid_ir keep their last value.
- Reset asserted mid-request: the request is abandoned. Memory must tolerate imem_read dropping.
- Latency: imem_resp at cycle N -> ifid_valid/ifid_ir valid at cycle N+1.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall_cnt (16) and perf_flush_cnt (16), both reset to 0.
  - perf_stall_cnt increments each cycle that stall=1 and ifid_valid=1.
  - perf_flush_cnt increments on each redirect pulse.
  - Both saturate at 16'hFFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, PC_RESET=16'h0000, memory responds 1 cycle after each request with 16'h1042 (ADD R0,R1,R2) at 0x0000 and 16'h5FE0 (AND imm) at 0x0002.
  - Required: imem_address 0x0000 then 0x0002.
  - First fetch: ifid_ir=16'h1042, ifid_pc=0x0002, ifid_opcode=4'h1, ifid_imm_check=0.
  - Next: ifid_ir=16'h5FE0, ifid_imm_check=1.
- stall=1 for 3 cycles while a resp arrives.
  - Required: IF/ID holds its old instruction; imem_read=0 during HOLD; no new address issued.
  - On stall drop: the held instruction appears in IF/ID next cycle and pc advances by 2.
- redirect to 16'h0100 two cycles into a 4-cycle memory latency.
  - Required: imem_address stays at the old address until resp; that rdata is discarded; ifid_valid=0.
  - The next request goes to 0x0100.
- redirect and imem_resp in the same cycle, with stall=1.
  - Required: ifid_valid=0 next cycle (flush beats stall); next imem_address=redirect_pc.
- pc=16'hFFFE fetch completes.
  - Required: ifid_pc=16'h0000; next imem_address=16'h0000.
- reset_n pulsed low mid-request (async, between edges).
  - Required: imem_read=0 and ifid_valid=0 immediately; after release, fetch restarts at PC_RESET.
  - With FETCH_PERF_CNT_EN: both counters read 0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory read channel between the IF stage and instruction memory.
// master: the fetch stage (issues requests); slave: the memory (returns data).
interface fetch_stage_if;
    logic        imem_read;
    logic [15:0] imem_address;
    logic        imem_resp;
    logic [15:0] imem_rdata;

    modport master (
        output imem_read,
        output imem_address,
        input  imem_resp,
        input  imem_rdata
    );

    modport slave (
        input  imem_read,
        input  imem_address,
        output imem_resp,
        output imem_rdata
    );
endinterface : fetch_stage_if

// File: rtl/fetch_stage.sv
// IF stage of the pipelined LC-3b core.
// Owns the PC and the single-outstanding instruction-memory read, fills the
// IF/ID latch and pre-extracts the decode fields used by the control ROM.
// Optional build macro FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module fetch_stage #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_stage_if.master imem,
    input  logic          stall,
    input  logic          redirect,
    input  logic [15:0]   redirect_pc,
    output logic          ifid_valid,
    output logic [15:0]   ifid_pc,
    output logic [15:0]   ifid_ir,
    output logic [3:0]    ifid_opcode,
    output logic          ifid_imm_check,
    output logic          ifid_jsr_check,
    output logic          ifid_rshf_check
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]   perf_stall_cnt,
    output logic [15:0]   perf_flush_cnt
`endif
);

    // REQ:   a request is (or is about to be) on the bus at pc.
    // HOLD:  a response arrived under stall; it waits in the hold register.
    // DRAIN: a redirect hit an outstanding request; wait out its response.
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] drain_addr_q, drain_addr_d;
    logic        read_q, read_d;
    logic [15:0] hold_pc_q, hold_pc_d;
    logic [15:0] hold_ir_q, hold_ir_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [15:0] ifid_pc_q, ifid_pc_d;
    logic [15:0] ifid_ir_q, ifid_ir_d;

    logic        load_new;
    logic [15:0] new_pc;
    logic [15:0] new_ir;
    logic [15:0] pc_plus2;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
`endif

    // 16-bit wrap from 16'hFFFE to 16'h0000 is intentional.
    assign pc_plus2 = pc_q + 16'd2;

    // Next-state, PC, hold register and IF/ID latch computation.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        hold_pc_d    = hold_pc_q;
        hold_ir_d    = hold_ir_q;
        load_new     = 1'b0;
        new_pc       = hold_pc_q;
        new_ir       = hold_ir_q;

        unique case (state_q)
            ST_REQ: begin
                if (read_q) begin
                    if (imem.imem_resp) begin
                        if (redirect) begin
                            // Fetched word belongs to the flushed path.
                            pc_d = redirect_pc;
                        end else if (stall) begin
                            hold_pc_d = pc_plus2;
                            hold_ir_d = imem.imem_rdata;
                            state_d   = ST_HOLD;
                        end else begin
                            load_new = 1'b1;
                            new_pc   = pc_plus2;
                            new_ir   = imem.imem_rdata;
                            pc_d     = pc_plus2;
                        end
                    end else if (redirect) begin
                        // Keep the bus address stable until the old response lands.
                        pc_d         = redirect_pc;
                        drain_addr_d = pc_q;
                        state_d      = ST_DRAIN;
                    end
                end else if (redirect) begin
                    // First cycle after reset: nothing is on the bus yet.
                    pc_d = redirect_pc;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = ST_REQ;
                end else if (!stall) begin
                    load_new = 1'b1;
                    pc_d     = pc_plus2;
                    state_d  = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem.imem_resp) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        read_d = (state_d != ST_HOLD);
        addr_d = (state_d == ST_DRAIN) ? drain_addr_d : pc_d;

        // Flush beats stall; stall beats a new instruction; otherwise a bubble.
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_ir_d    = ifid_ir_q;
        if (redirect) begin
            ifid_valid_d = 1'b0;
        end else if (stall) begin
            ifid_valid_d = ifid_valid_q;
        end else if (load_new) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = new_pc;
            ifid_ir_d    = new_ir;
        end else begin
            ifid_valid_d = 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && ifid_valid_q && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (redirect && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end
`endif

    // State and output registers; async reset drops the bus request at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_REQ;
            pc_q         <= PC_RESET;
            addr_q       <= PC_RESET;
            drain_addr_q <= PC_RESET;
            read_q       <= 1'b0;
            // NOTE: the hold register is reset too, so a stale word can never leak after reset.
            hold_pc_q    <= 16'h0000;
            hold_ir_q    <= 16'h0000;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 16'h0000;
            ifid_ir_q    <= 16'h0000;
`ifdef FETCH_PERF_CNT_EN
            stall_cnt_q  <= 16'h0000;
            flush_cnt_q  <= 16'h0000;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            drain_addr_q <= drain_addr_d;
            read_q       <= read_d;
            hold_pc_q    <= hold_pc_d;
            hold_ir_q    <= hold_ir_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_ir_q    <= ifid_ir_d;
`ifdef FETCH_PERF_CNT_EN
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
`endif
        end
    end

    assign imem.imem_read    = read_q;
    assign imem.imem_address = addr_q;

    assign ifid_valid      = ifid_valid_q;
    assign ifid_pc         = ifid_pc_q;
    assign ifid_ir         = ifid_ir_q;
    assign ifid_opcode     = ifid_ir_q[15:12];
    assign ifid_imm_check  = ifid_ir_q[5];
    assign ifid_jsr_check  = ifid_ir_q[11];
    assign ifid_rshf_check = ifid_ir_q[4];

`ifdef FETCH_PERF_CNT_EN
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/redirect/latency traffic, compared against a transaction-level model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ifid_valid;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_ir;
    logic [3:0]  ifid_opcode;
    logic        ifid_imm_check;
    logic        ifid_jsr_check;
    logic        ifid_rshf_check;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    fetch_stage_if imem_bus ();

    fetch_stage #(.PC_RESET(16'h0000)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem            (imem_bus),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .ifid_valid      (ifid_valid),
        .ifid_pc         (ifid_pc),
        .ifid_ir         (ifid_ir),
        .ifid_opcode     (ifid_opcode),
        .ifid_imm_check  (ifid_imm_check),
        .ifid_jsr_check  (ifid_jsr_check),
        .ifid_rshf_check (ifid_rshf_check)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h1042;
        if (a == 16'h0002) return 16'h5FE0;
        return (a * 16'h9E37) ^ 16'h3C5A;
    endfunction

    // ---------------- reference model (request/transaction level) ----------
    logic [15:0] m_pc;      // next instruction address the program will fetch
    logic [15:0] m_addr;    // address of the request currently on the bus
    logic        m_req_on;  // a request is on the bus
    logic        m_stale;   // the request on the bus was flushed
    logic        h_valid;   // a fetched word waits for the stall to lift
    logic [15:0] h_pc, h_ir;
    logic        e_valid;
    logic [15:0] e_pc, e_ir;
    logic [15:0] e_stall_cnt, e_flush_cnt;
    int          mem_cnt, mem_lat, fixed_lat;

    task automatic model_reset();
        m_pc = 16'h0000; m_addr = 16'h0000; m_req_on = 1'b0; m_stale = 1'b0;
        h_valid = 1'b0; h_pc = 16'h0000; h_ir = 16'h0000;
        e_valid = 1'b0; e_pc = 16'h0000; e_ir = 16'h0000;
        e_stall_cnt = 16'h0000; e_flush_cnt = 16'h0000;
        mem_cnt = 0;
    endtask

    task automatic start_req();
        m_req_on = 1'b1;
        m_addr   = m_pc;
        m_stale  = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic r, input logic [15:0] rpc,
                              input logic resp, input logic [15:0] rd);
        logic        got_new;
        logic [15:0] n_pc, n_ir;
        got_new = 1'b0;
        n_pc    = 16'h0000;
        n_ir    = 16'h0000;
        if (s && e_valid && e_stall_cnt != 16'hFFFF) e_stall_cnt = e_stall_cnt + 16'd1;
        if (r && e_flush_cnt != 16'hFFFF) e_flush_cnt = e_flush_cnt + 16'd1;

        if (!m_req_on) begin
            if (h_valid) begin
                if (r) begin
                    h_valid = 1'b0; m_pc = rpc; start_req();
                end else if (!s) begin
                    got_new = 1'b1; n_pc = h_pc; n_ir = h_ir;
                    h_valid = 1'b0; m_pc = m_pc + 16'd2; start_req();
                end
            end else begin
                if (r) m_pc = rpc;
                start_req();
            end
        end else if (resp) begin
            if (m_stale || r) begin
                if (r) m_pc = rpc;
                start_req();
            end else if (s) begin
                h_valid = 1'b1; h_pc = m_pc + 16'd2; h_ir = rd; m_req_on = 1'b0;
            end else begin
                got_new = 1'b1; n_pc = m_pc + 16'd2; n_ir = rd;
                m_pc = m_pc + 16'd2; start_req();
            end
        end else if (r) begin
            m_pc = rpc; m_stale = 1'b1;
        end

        if (r) e_valid = 1'b0;
        else if (s) e_valid = e_valid;
        else if (got_new) begin e_valid = 1'b1; e_pc = n_pc; e_ir = n_ir; end
        else e_valid = 1'b0;
    endtask

    task automatic compare_all();
        check("imem_read", 32'(imem_bus.imem_read), 32'(m_req_on));
        if (m_req_on) check("imem_address", 32'(imem_bus.imem_address), 32'(m_addr));
        check("ifid_valid", 32'(ifid_valid), 32'(e_valid));
        check("ifid_pc", 32'(ifid_pc), 32'(e_pc));
        check("ifid_ir", 32'(ifid_ir), 32'(e_ir));
        check("ifid_opcode", 32'(ifid_opcode), 32'(e_ir >> 12));
        check("ifid_imm_check", 32'(ifid_imm_check), 32'((e_ir >> 5) & 16'd1));
        check("ifid_jsr_check", 32'(ifid_jsr_check), 32'((e_ir >> 11) & 16'd1));
        check("ifid_rshf_check", 32'(ifid_rshf_check), 32'((e_ir >> 4) & 16'd1));
`ifdef FETCH_PERF_CNT_EN
        check("perf_stall_cnt", 32'(perf_stall_cnt), 32'(e_stall_cnt));
        check("perf_flush_cnt", 32'(perf_flush_cnt), 32'(e_flush_cnt));
`endif
    endtask

    // One clock: drive at negedge, step model at posedge, compare at next negedge.
    task automatic cycle(input logic s, input logic r, input logic [15:0] rpc);
        logic        resp, was_on;
        logic [15:0] rd;
        was_on = m_req_on;
        resp   = m_req_on && (mem_cnt >= mem_lat);
        rd     = resp ? mem_word(m_addr) : 16'($urandom);
        stall  = s; redirect = r; redirect_pc = rpc;
        imem_bus.imem_resp  = resp;
        imem_bus.imem_rdata = rd;
        @(posedge clk);
        model_step(s, r, rpc, resp, rd);
        if (!was_on || resp || !m_req_on) begin
            mem_cnt = 0;
            mem_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        end else begin
            mem_cnt++;
        end
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [15:0] tgt;
        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        imem_bus.imem_resp = 1'b0; imem_bus.imem_rdata = 16'h0000;
        fixed_lat = 1; mem_lat = 1;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset imem_read", 32'(imem_bus.imem_read), 32'd0);
        check("reset ifid_valid", 32'(ifid_valid), 32'd0);
        check("reset ifid_ir", 32'(ifid_ir), 32'd0);
        check("reset ifid_pc", 32'(ifid_pc), 32'd0);
        reset_n = 1'b1;

        // Reset release and first two fetches (1-cycle memory).
        cycle(0, 0, 16'h0);                                             // 1
        check("first addr", 32'(imem_bus.imem_address), 32'h0000);
        cycle(0, 0, 16'h0);                                             // 2
        cycle(0, 0, 16'h0);                                             // 3
        check("fetch0 ir", 32'(ifid_ir), 32'h1042);
        check("fetch0 pc", 32'(ifid_pc), 32'h0002);
        check("fetch0 opcode", 32'(ifid_opcode), 32'h1);
        check("fetch0 imm", 32'(ifid_imm_check), 32'd0);
        check("second addr", 32'(imem_bus.imem_address), 32'h0002);
        cycle(0, 0, 16'h0);                                             // 4
        cycle(0, 0, 16'h0);                                             // 5
        check("fetch1 ir", 32'(ifid_ir), 32'h5FE0);
        check("fetch1 imm", 32'(ifid_imm_check), 32'd1);

        // Stall for 3 cycles while a response arrives.
        cycle(1, 0, 16'h0);                                             // 6
        cycle(1, 0, 16'h0);                                             // 7
        check("hold read", 32'(imem_bus.imem_read), 32'd0);
        check("hold ir", 32'(ifid_ir), 32'h5FE0);
        cycle(1, 0, 16'h0);                                             // 8
        check("hold read2", 32'(imem_bus.imem_read), 32'd0);
        check("hold valid", 32'(ifid_valid), 32'd1);
        fixed_lat = 4;
        cycle(0, 0, 16'h0);                                             // 9
        check("unstall ir", 32'(ifid_ir), 32'(mem_word(16'h0004)));
        check("unstall pc", 32'(ifid_pc), 32'h0006);
        check("unstall addr", 32'(imem_bus.imem_address), 32'h0006);

        // Redirect two cycles into a 4-cycle latency.
        cycle(0, 0, 16'h0);                                             // 10
        cycle(0, 0, 16'h0);                                             // 11
        cycle(0, 1, 16'h0100);                                          // 12
        check("drain addr", 32'(imem_bus.imem_address), 32'h0006);
        check("drain valid", 32'(ifid_valid), 32'd0);
        cycle(0, 0, 16'h0);                                             // 13
        check("drain addr2", 32'(imem_bus.imem_address), 32'h0006);
        fixed_lat = 1;
        cycle(0, 0, 16'h0);                                             // 14
        check("drain discard", 32'(ifid_valid), 32'd0);
        check("redirect addr", 32'(imem_bus.imem_address), 32'h0100);

        // Redirect and response together under stall.
        cycle(0, 0, 16'h0);                                             // 15
        cycle(0, 0, 16'h0);                                             // 16
        check("target ir", 32'(ifid_ir), 32'(mem_word(16'h0100)));
        cycle(1, 0, 16'h0);                                             // 17
        cycle(1, 1, 16'h0200);                                          // 18
        check("flush beats stall", 32'(ifid_valid), 32'd0);
        check("flush addr", 32'(imem_bus.imem_address), 32'h0200);

        // Fetch at 16'hFFFE wraps PC.
        cycle(0, 1, 16'hFFFE);                                          // 19
        cycle(0, 0, 16'h0);                                             // 20
        check("wrap req addr", 32'(imem_bus.imem_address), 32'hFFFE);
        cycle(0, 0, 16'h0);                                             // 21
        cycle(0, 0, 16'h0);                                             // 22
        check("wrap ifid_pc", 32'(ifid_pc), 32'h0000);
        check("wrap addr", 32'(imem_bus.imem_address), 32'h0000);

        // Random traffic.
        fixed_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            tgt = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 7) == 0) tgt = 16'hFFFE;
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0), tgt);
        end

        // Asynchronous reset in the middle of a request.
        for (int i = 0; i < 20 && !m_req_on; i++) cycle(0, 0, 16'h0);
        check("pre-reset request", 32'(m_req_on), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async reset read", 32'(imem_bus.imem_read), 32'd0);
        check("async reset valid", 32'(ifid_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("async reset stall cnt", 32'(perf_stall_cnt), 32'd0);
        check("async reset flush cnt", 32'(perf_flush_cnt), 32'd0);
`endif
        stall = 1'b0; redirect = 1'b0; imem_bus.imem_resp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        fixed_lat = 1; mem_lat = 1;
        cycle(0, 0, 16'h0);
        check("restart addr", 32'(imem_bus.imem_address), 32'h0000);
        check("restart read", 32'(imem_bus.imem_read), 32'd1);
        cycle(0, 0, 16'h0);
        cycle(0, 0, 16'h0);
        check("restart ir", 32'(ifid_ir), 32'h1042);
        fixed_lat = -1;
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                  16'($urandom) & 16'hFFFE);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_stage
